// File: rtl/spi_serializer.sv
// spi_serializer: parallel-in / serial-out SPI transmitter with a one-word holding buffer.
// Build option SPI_SERIALIZER_LSB_FIRST_EN: when defined, words are shifted out LSB first.
module spi_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_ready,
  output logic             o_bit,
  output logic             o_busy,
  output logic             o_done
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  function automatic logic [WIDTH-1:0] f_shift_next(input logic [WIDTH-1:0] v);
`ifdef SPI_SERIALIZER_LSB_FIRST_EN
    f_shift_next = {1'b0, v[WIDTH-1:1]};
`else
    f_shift_next = {v[WIDTH-2:0], 1'b0};
`endif
  endfunction

  function automatic logic f_line_bit(input logic [WIDTH-1:0] v);
`ifdef SPI_SERIALIZER_LSB_FIRST_EN
    f_line_bit = v[0];
`else
    f_line_bit = v[WIDTH-1];
`endif
  endfunction

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_buf;
  logic             r_buf_full;
  logic [CW-1:0]    r_cnt;
  logic             r_done;

  logic [0:0]       w_state_nxt;
  logic [WIDTH-1:0] w_shift_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_done_nxt;
  logic             w_take_buf;
  logic             w_accept;
  logic             w_buf_full_nxt;

  assign w_accept = i_valid & ~r_buf_full;

  // Sequencing: buffer-to-shifter transfer, per-strobe shifting and end-of-word handling.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    w_take_buf  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_buf_full) begin
          w_take_buf  = 1'b1;
          w_shift_nxt = r_buf;
          w_cnt_nxt   = CNT_ZERO;
          w_state_nxt = ST_SHIFT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (enable) begin
          if (r_cnt == CNT_LAST) begin
            w_done_nxt = 1'b1;
            // A waiting word follows immediately so the line sees no idle bit.
            if (r_buf_full) begin
              w_take_buf  = 1'b1;
              w_shift_nxt = r_buf;
              w_cnt_nxt   = CNT_ZERO;
              w_state_nxt = ST_SHIFT;
            end else begin
              w_shift_nxt = f_shift_next(r_shift);
              w_cnt_nxt   = CNT_ZERO;
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_shift_nxt = f_shift_next(r_shift);
            w_cnt_nxt   = r_cnt + CNT_ONE;
          end
        end else begin
          w_state_nxt = ST_SHIFT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_shift_nxt = {WIDTH{1'b0}};
        w_cnt_nxt   = CNT_ZERO;
      end
    endcase
  end

  // Holding-buffer occupancy: an accept and a transfer never fall on the same edge.
  always_comb begin
    if (w_accept) begin
      w_buf_full_nxt = 1'b1;
    end else if (w_take_buf) begin
      w_buf_full_nxt = 1'b0;
    end else begin
      w_buf_full_nxt = r_buf_full;
    end
  end

  // State, shifter, counter and done registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_shift <= {WIDTH{1'b0}};
      r_cnt   <= CNT_ZERO;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Holding buffer capture on the accepting edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_buf      <= {WIDTH{1'b0}};
      r_buf_full <= 1'b0;
    end else begin
      r_buf_full <= w_buf_full_nxt;
      if (w_accept) begin
        r_buf <= i_data;
      end else begin
        r_buf <= r_buf;
      end
    end
  end

  assign o_ready = ~r_buf_full;
  assign o_busy  = (r_state == ST_SHIFT);
  assign o_bit   = (r_state == ST_SHIFT) ? f_line_bit(r_shift) : 1'b0;
  assign o_done  = r_done;

endmodule

// File: tb/tb_spi_serializer.sv
// Directed self-checking bench for spi_serializer with a word scoreboard and loopback receiver.
module tb_spi_serializer;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       i_valid;
  logic [7:0] i_data;
  logic       o_ready;
  logic       o_bit;
  logic       o_busy;
  logic       o_done;

  spi_serializer #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .i_valid (i_valid),
    .i_data  (i_data),
    .o_ready (o_ready),
    .o_bit   (o_bit),
    .o_busy  (o_busy),
    .o_done  (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  src_q[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  rx;
  int          rx_cnt;
  int          n_bits;
  int          n_words;
  logic [63:0] bitlog;
  int          cyc;
  int          n_done;
  int          last_done_cyc;
  int          done_gap;
  int          busy_gap;
  int          rdy_low;
  logic        seen_busy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    n_done        = 0;
    last_done_cyc = -1;
    done_gap      = 0;
    busy_gap      = 0;
    rdy_low       = 0;
    seen_busy     = 1'b0;
    bitlog        = 64'd0;
    n_bits        = 0;
    n_words       = 0;
  endtask

  // One clock: called at a negedge, drives inputs, models receiver and done, returns at next negedge.
  task automatic cycle(input logic en);
    logic       v;
    logic [7:0] d;
    logic       bit_pre;
    logic       busy_pre;
    logic       rdy_pre;
    logic       exp_done;
    logic [7:0] e;
    v = (src_q.size() > 0);
    d = v ? src_q[0] : 8'h00;
    enable  = en;
    i_valid = v;
    i_data  = d;
    #1;
    bit_pre  = o_bit;
    busy_pre = o_busy;
    rdy_pre  = o_ready;
    if (v && rdy_pre) begin
      exp_q.push_back(d);
      void'(src_q.pop_front());
    end
    exp_done = 1'b0;
    if (en && busy_pre) begin
`ifdef SPI_SERIALIZER_LSB_FIRST_EN
      rx = {bit_pre, rx[7:1]};
`else
      rx = {rx[6:0], bit_pre};
`endif
      bitlog = {bitlog[62:0], bit_pre};
      n_bits++;
      rx_cnt++;
      if (rx_cnt == 8) exp_done = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check("done_pulse", o_done, exp_done);
    if (exp_done) begin
      rx_cnt = 0;
      n_words++;
      check("word_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rx_word", rx, e);
      end
    end
    if (o_done) begin
      if (last_done_cyc >= 0) done_gap = cyc - last_done_cyc;
      last_done_cyc = cyc;
      n_done++;
    end
    if (o_busy) seen_busy = 1'b1;
    else if (seen_busy && n_done < 2) busy_gap++;
    if (!o_ready) rdy_low++;
  endtask

  task automatic run(input int period, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (src_q.size() == 0 && exp_q.size() == 0 && rx_cnt == 0 && !o_busy) break;
      cycle((i % period) == (period - 1));
    end
    check("drain_src", src_q.size(), 0);
    check("drain_exp", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, o_ready, 1);
    check({tag, "_busy"},  o_busy,  0);
    check({tag, "_bit"},   o_bit,   0);
    check({tag, "_done"},  o_done,  0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; enable = 1'b0; i_valid = 1'b0; i_data = 8'h00;
    rx = 8'h00; rx_cnt = 0; cyc = 0;
    clear_stats();
    #2;
    check_reset_outputs("rst_async");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_release");

    // Idle: enable strobes without a word must not disturb anything.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1);
      check("idle_ready", o_ready, 1);
      check("idle_busy",  o_busy,  0);
      check("idle_bit",   o_bit,   0);
    end
    check("idle_done_cnt", n_done, 0);

    // Single word with enable every 4th clock.
    clear_stats();
    src_q.push_back(8'hA5);
    run(4, 200);
    check("a5_done_cnt", n_done, 1);
    check("a5_words", n_words, 1);
    check("a5_bits", bitlog[7:0], 8'hA5);
    check("a5_busy_end", o_busy, 0);

    // Back-to-back words, enable held high.
    clear_stats();
    src_q.push_back(8'h3C);
    src_q.push_back(8'hC3);
    run(1, 200);
    check("b2b_nbits", n_bits, 16);
    check("b2b_bits", bitlog[15:0], 16'h3CC3);
    check("b2b_done_cnt", n_done, 2);
    check("b2b_done_gap", done_gap, 8);
    check("b2b_busy_gap", busy_gap, 0);

    // Backpressure: three words offered with valid held.
    clear_stats();
    src_q.push_back(8'h11);
    src_q.push_back(8'h22);
    src_q.push_back(8'h33);
    run(1, 300);
    check("bp_words", n_words, 3);
    check("bp_ready_dropped", rdy_low > 0, 1);
    check("bp_bits", bitlog[23:0], 24'h112233);

    // Reset mid-word after three bits of 0xFF.
    clear_stats();
    src_q.push_back(8'hFF);
    for (int i = 0; i < 20; i++) begin
      if (rx_cnt == 3) break;
      cycle(1'b1);
    end
    check("mid_bits_before_rst", rx_cnt, 3);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("mid_rst_async");
    src_q.delete();
    exp_q.delete();
    rx_cnt = 0;
    rx = 8'h00;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst_release");
    @(negedge clk);

    // 0x81 after the reset, including first-bit latency.
    clear_stats();
    src_q.push_back(8'h81);
    cycle(1'b1);
    check("lat_busy_after_accept", o_busy, 0);
    cycle(1'b1);
    check("lat_busy", o_busy, 1);
    check("lat_first_bit", o_bit, 1);
    run(1, 100);
    check("w81_bits", bitlog[7:0], 8'h81);
    check("w81_words", n_words, 1);

    // Bit order on a single-bit word.
    clear_stats();
    src_q.push_back(8'h01);
    run(1, 100);
`ifdef SPI_SERIALIZER_LSB_FIRST_EN
    check("w01_order", bitlog[7:0], 8'b1000_0000);
`else
    check("w01_order", bitlog[7:0], 8'b0000_0001);
`endif
    check("w01_busy_end", o_busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
